// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode constants, state encoding and opcode classes for multicycle_control
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    OC_R, OC_I, OC_LOAD, OC_STORE, OC_BRANCH, OC_NOP
  } opclass_e;

  function automatic opclass_e classify(input logic [6:0] op);
    case (op)
      OP_R:      classify = OC_R;
      OP_I_ALU:  classify = OC_I;
      OP_LOAD:   classify = OC_LOAD;
      OP_STORE:  classify = OC_STORE;
      OP_BRANCH: classify = OC_BRANCH;
      default:   classify = OC_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - ack wait counter; expired flags the stall cycle that would reach limit
module ctrl_wait_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + W'(1);
    end
  end

  // A zero limit disables the timeout; an ack in the limit cycle drops enable, so ack wins.
  assign expired = enable && (limit != '0) && (cnt == limit - W'(1));

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle fetch/decode/exec/mem/wb control FSM
// Optional macro CTRL_ILLEGAL_TRAP_EN: unlisted opcodes halt and set illegal instead of acting as NOP.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [31:0] ir,
  input  logic        branch_cond,
  output logic        pc_we,
  output logic        pc_src,
  output logic        rf_we,
  output logic        alu_src_imm,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic        bus_err,
  output logic        illegal
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e   st, st_nxt;
  opclass_e cls;
  logic     tmr_clear, tmr_en, tmr_exp;
  logic     set_bus_err;

  assign cls   = classify(ir[6:0]);
  assign state = st;

  // Counter restarts on every state change, so it is zero on entry to FETCH and MEM.
  assign tmr_en    = (st == FETCH && !imem_ack) || (st == MEM && !dmem_ack);
  assign tmr_clear = (st_nxt != st);

  ctrl_wait_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .limit   (TW'(TIMEOUT_CYCLES)),
    .expired (tmr_exp)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic set_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (set_illegal) begin
      illegal <= 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= S_RST;
      ir      <= '0;
      bus_err <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st == FETCH && imem_ack) ir <= imem_rdata;
      if (set_bus_err) bus_err <= 1'b1;
    end
  end

  always_comb begin
    st_nxt      = st;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    rf_we       = 1'b0;
    alu_src_imm = 1'b0;
    mem_to_reg  = 1'b0;
    set_bus_err = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    set_illegal = 1'b0;
`endif
    case (st)
      S_RST: st_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          st_nxt = DECODE;
        end else if (tmr_exp) begin
          st_nxt      = HALT;
          set_bus_err = 1'b1;
        end
      end
      DECODE: begin
        if (cls == OC_NOP) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          st_nxt      = HALT;
          set_illegal = 1'b1;
`else
          st_nxt = WB;
`endif
        end else begin
          st_nxt = EXEC;
        end
      end
      EXEC: begin
        alu_src_imm = (cls == OC_I) || (cls == OC_LOAD) || (cls == OC_STORE);
        case (cls)
          OC_LOAD, OC_STORE: st_nxt = MEM;
          OC_BRANCH: begin
            pc_we  = 1'b1;
            pc_src = branch_cond;
            st_nxt = FETCH;
          end
          default: st_nxt = WB;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == OC_STORE);
        if (dmem_ack) begin
          if (cls == OC_STORE) begin
            pc_we  = 1'b1;
            st_nxt = FETCH;
          end else begin
            st_nxt = WB;
          end
        end else if (tmr_exp) begin
          st_nxt      = HALT;
          set_bus_err = 1'b1;
        end
      end
      WB: begin
        rf_we      = (cls == OC_R) || (cls == OC_I) || (cls == OC_LOAD);
        mem_to_reg = (cls == OC_LOAD);
        pc_we      = 1'b1;
        st_nxt     = FETCH;
      end
      HALT: st_nxt = HALT;
      default: st_nxt = S_RST;
    endcase
  end

endmodule
